// File: rtl/fifo_drain_ctrl.sv
// AXI4-Lite master that polls a simple_fifo, pops up to MAX_BURST words per poll and streams them out.
// Optional response timeout is compiled in with `define DRAIN_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | disabled; services a pending flush, otherwise waits for enable
// WAIT   | poll interval countdown; pending flush takes priority
// CNT_AR | read address issued for the occupancy register
// CNT_R  | waiting for the occupancy value
// DAT_AR | read address issued for the data register (pops one word)
// DAT_R  | waiting for the popped word
// STREAM | word presented on the stream port until accepted
// FL_AW  | flush write: address and data channels in flight
// FL_B   | flush write: waiting for the write response
module fifo_drain_ctrl #(
   parameter int          C_M_AXI_ADDR_WIDTH = 32,
   parameter int          C_M_AXI_DATA_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
   parameter logic [31:0] DATA_OFFSET        = 32'h0,
   parameter logic [31:0] COUNT_OFFSET       = 32'h4,
   parameter logic [31:0] CTRL_OFFSET        = 32'h8,
   parameter int          MAX_BURST          = 16,
   parameter int          POLL_INTERVAL      = 64,
   parameter int          TIMEOUT_CYCLES     = 256
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic                            enable,
   input  logic                            flush_req,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]                      m_axi_arprot,
   output logic                            m_axi_arvalid,
   input  logic                            m_axi_arready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                      m_axi_rresp,
   input  logic                            m_axi_rvalid,
   output logic                            m_axi_rready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]                      m_axi_awprot,
   output logic                            m_axi_awvalid,
   input  logic                            m_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                            m_axi_wvalid,
   input  logic                            m_axi_wready,
   input  logic [1:0]                      m_axi_bresp,
   input  logic                            m_axi_bvalid,
   output logic                            m_axi_bready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            busy,
   output logic                            err,
   input  logic                            err_clr
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam int TW = $clog2(POLL_INTERVAL + 1);
   localparam logic [AW-1:0] CNT_ADDR  = AW'(BASE_ADDR + COUNT_OFFSET);
   localparam logic [AW-1:0] DAT_ADDR  = AW'(BASE_ADDR + DATA_OFFSET);
   localparam logic [AW-1:0] CTRL_ADDR = AW'(BASE_ADDR + CTRL_OFFSET);
   localparam logic [TW-1:0] POLL_LOAD = TW'(POLL_INTERVAL);
   localparam logic [15:0]   MAX_B16   = 16'(MAX_BURST);
   localparam logic [7:0]    MAX_B8    = 8'(MAX_BURST);
   localparam logic [1:0]    OKAY      = 2'b00;

   typedef enum logic [3:0] {
      IDLE, WAIT, CNT_AR, CNT_R, DAT_AR, DAT_R, STREAM, FL_AW, FL_B
   } state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [7:0]    remaining;
   logic          flush_pend;

`ifdef DRAIN_TIMEOUT_EN
   localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TOW-1:0] TO_LOAD = TOW'(TIMEOUT_CYCLES);
   logic [TOW-1:0] to_tmr;
   logic           resp_wait;
   logic           resp_seen;
   assign resp_wait = (state == CNT_R) || (state == DAT_R) || (state == FL_B);
   assign resp_seen = (state == FL_B) ? m_axi_bvalid : m_axi_rvalid;
`endif

   assign m_axi_arprot = 3'b000;
   assign m_axi_awprot = 3'b000;
   assign m_axi_wstrb  = '1;
   assign busy         = (state != IDLE) && (state != WAIT);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state         <= IDLE;
         timer         <= '0;
         remaining     <= '0;
         flush_pend    <= 1'b0;
         err           <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
`ifdef DRAIN_TIMEOUT_EN
         to_tmr        <= TO_LOAD;
`endif
      end else begin
         // a new error later in this block overrides the clear
         if (err_clr) err <= 1'b0;

         case (state)
            IDLE, WAIT: begin
               if (flush_pend) begin
                  m_axi_awaddr  <= CTRL_ADDR;
                  m_axi_wdata   <= DW'(1);
                  m_axi_awvalid <= 1'b1;
                  m_axi_wvalid  <= 1'b1;
                  state         <= FL_AW;
               end else if (state == IDLE) begin
                  if (enable) begin
                     timer <= POLL_LOAD;
                     state <= WAIT;
                  end
               end else if (!enable) begin
                  state <= IDLE;
               end else if (timer <= TW'(1)) begin
                  timer         <= '0;
                  m_axi_araddr  <= CNT_ADDR;
                  m_axi_arvalid <= 1'b1;
                  state         <= CNT_AR;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            CNT_AR, DAT_AR: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  state         <= (state == CNT_AR) ? CNT_R : DAT_R;
               end
            end
            CNT_R: begin
               if (m_axi_rvalid) begin
                  m_axi_rready <= 1'b0;
                  if (m_axi_rresp != OKAY || m_axi_rdata[15:0] == 16'd0) begin
                     if (m_axi_rresp != OKAY) err <= 1'b1;
                     remaining <= '0;
                     timer     <= POLL_LOAD;
                     state     <= WAIT;
                  end else begin
                     remaining     <= (m_axi_rdata[15:0] > MAX_B16) ? MAX_B8 : m_axi_rdata[7:0];
                     m_axi_araddr  <= DAT_ADDR;
                     m_axi_arvalid <= 1'b1;
                     state         <= DAT_AR;
                  end
               end
            end
            DAT_R: begin
               if (m_axi_rvalid) begin
                  m_axi_rready <= 1'b0;
                  if (m_axi_rresp != OKAY) begin
                     err       <= 1'b1;
                     remaining <= '0;
                     timer     <= POLL_LOAD;
                     state     <= WAIT;
                  end else begin
                     m_axis_tdata  <= m_axi_rdata;
                     m_axis_tvalid <= 1'b1;
                     state         <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (m_axis_tready) begin
                  m_axis_tvalid <= 1'b0;
                  remaining     <= remaining - 8'd1;
                  if (remaining > 8'd1 && enable) begin
                     m_axi_araddr  <= DAT_ADDR;
                     m_axi_arvalid <= 1'b1;
                     state         <= DAT_AR;
                  end else if (enable) begin
                     timer <= POLL_LOAD;
                     state <= WAIT;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            FL_AW: begin
               if (m_axi_awready) m_axi_awvalid <= 1'b0;
               if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
               if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                  m_axi_bready <= 1'b1;
                  state        <= FL_B;
               end
            end
            FL_B: begin
               if (m_axi_bvalid) begin
                  m_axi_bready <= 1'b0;
                  flush_pend   <= 1'b0;
                  if (m_axi_bresp != OKAY) err <= 1'b1;
                  timer <= POLL_LOAD;
                  state <= WAIT;
               end
            end
            default: state <= IDLE;
         endcase

`ifdef DRAIN_TIMEOUT_EN
         if (resp_wait && !resp_seen) begin
            if (to_tmr <= TOW'(1)) begin
               err          <= 1'b1;
               m_axi_rready <= 1'b0;
               m_axi_bready <= 1'b0;
               flush_pend   <= 1'b0;
               state        <= IDLE;
               to_tmr       <= TO_LOAD;
            end else begin
               to_tmr <= to_tmr - 1'b1;
            end
         end else begin
            to_tmr <= TO_LOAD;
         end
`endif

         // a request arriving while the previous flush completes is kept
         if (flush_req) flush_pend <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: a simple_fifo slave model, a push-order scoreboard for the stream,
// a table of occupancy scenarios, hand-written corner sequences and a randomized phase.
module tb_fifo_drain_ctrl;

   localparam int          MAXB   = 16;
   localparam int          POLL   = 64;
   localparam int          TO_CYC = 256;
   localparam logic [31:0] DAT_A  = 32'h0;
   localparam logic [31:0] CNT_A  = 32'h4;
   localparam logic [31:0] CTRL_A = 32'h8;

   logic ACLK = 1'b0, ARESETN = 1'b0;
   logic enable, flush_req, err_clr;
   logic [31:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata, m_axis_tdata;
   logic [2:0]  m_axi_arprot, m_axi_awprot;
   logic [3:0]  m_axi_wstrb;
   logic [1:0]  m_axi_rresp, m_axi_bresp;
   logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
   logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic m_axi_bvalid, m_axi_bready, m_axis_tvalid, m_axis_tready, busy, err;

   fifo_drain_ctrl dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .flush_req(flush_req),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_awaddr(m_axi_awaddr),
      .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .busy(busy), .err(err), .err_clr(err_clr)
   );

   always #5 ACLK = ~ACLK;

   int tests = 0, fails = 0;

   // slave / model state
   logic [31:0] fifo_q[$];
   logic [31:0] exp_q[$];
   int unsigned pops_log[$];
   int unsigned idle_log[$];
   logic rnd_ready, stall_hold, withhold_r, slverr_next, poll_chk_en;
   logic rd_pend, aw_got, w_got, poll_open;
   logic [31:0] rd_addr, wr_addr, wr_data, last_awaddr, last_wdata, p_araddr, p_awaddr, p_wdata, p_tdata;
   logic [3:0]  p_wstrb, last_wstrb;
   logic p_ar_hs, p_r_hs, p_aw_hs, p_w_hs, p_b_hs, p_t_hold;
   int unsigned rd_wait, pops_cur, poll_exp, idle_run, got_n, n_writes, n_pushed;
   logic [31:0] next_word;

   typedef struct {
      int unsigned n_words;
      int unsigned p0, p1, p2;
   } vec_t;
   vec_t vec[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic slave_reset();
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = '0; m_axis_tready = 0;
      fifo_q.delete(); exp_q.delete();
      rd_pend = 0; aw_got = 0; w_got = 0; poll_open = 0; rd_wait = 0; pops_cur = 0;
      p_ar_hs = 0; p_r_hs = 0; p_aw_hs = 0; p_w_hs = 0; p_b_hs = 0; p_t_hold = 0;
      withhold_r = 0; slverr_next = 0; stall_hold = 0; idle_run = 0;
   endtask

   task automatic fill(input int unsigned n);
      for (int i = 0; i < int'(n); i++) begin
         fifo_q.push_back(next_word);
         exp_q.push_back(next_word);
         next_word = next_word + 1;
         n_pushed++;
      end
   endtask

   task automatic slave_step();
      logic [31:0] w;
      int unsigned c;
      // handshakes completed at the previous rising edge
      if (p_r_hs) m_axi_rvalid = 0;
      if (p_b_hs) m_axi_bvalid = 0;
      if (p_ar_hs) begin
         rd_pend = 1; rd_addr = p_araddr;
         rd_wait = rnd_ready ? $urandom_range(0, 3) : 0;
      end
      if (p_aw_hs) begin aw_got = 1; wr_addr = p_awaddr; end
      if (p_w_hs)  begin w_got = 1; wr_data = p_wdata; last_wstrb = p_wstrb; end

      m_axi_arready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_awready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axis_tready = stall_hold ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);

      if (rd_pend && !m_axi_rvalid && !withhold_r) begin
         if (rd_wait == 0) begin
            rd_pend = 0; m_axi_rvalid = 1; m_axi_rresp = 2'b00;
            if (rd_addr == CNT_A) begin
               c = fifo_q.size();
               m_axi_rdata = c;
               if (poll_open) begin
                  pops_log.push_back(pops_cur);
                  if (poll_chk_en) check("pops_per_poll", pops_cur, poll_exp);
               end
               poll_open = 1; pops_cur = 0;
               poll_exp = (c > MAXB) ? MAXB : c;
            end else begin
               w = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'hDEAD_BEEF;
               m_axi_rdata = w;
               pops_cur++;
               if (slverr_next) begin
                  m_axi_rresp = 2'b10; slverr_next = 0;
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
               end
            end
         end else rd_wait--;
      end

      if (aw_got && w_got && !m_axi_bvalid) begin
         aw_got = 0; w_got = 0; m_axi_bvalid = 1; m_axi_bresp = 2'b00;
         last_awaddr = wr_addr; last_wdata = wr_data; n_writes++;
         if (wr_addr == CTRL_A && wr_data == 32'd1) fifo_q.delete();
      end

      // handshakes that will complete at the next rising edge
      p_ar_hs = m_axi_arvalid && m_axi_arready;
      p_araddr = m_axi_araddr;
      if (p_ar_hs) begin
         check("ar_single_outstanding", {31'd0, rd_pend || m_axi_rvalid}, 0);
         check("araddr_known", {31'd0, m_axi_araddr == CNT_A || m_axi_araddr == DAT_A}, 1);
      end
      p_r_hs  = m_axi_rvalid && m_axi_rready;
      p_aw_hs = m_axi_awvalid && m_axi_awready; p_awaddr = m_axi_awaddr;
      p_w_hs  = m_axi_wvalid && m_axi_wready;   p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
      p_b_hs  = m_axi_bvalid && m_axi_bready;

      if (p_t_hold && m_axis_tvalid) check("tdata_stable", m_axis_tdata, p_tdata);
      if (m_axis_tvalid && m_axis_tready) begin
         w = (exp_q.size() > 0) ? exp_q.pop_front() : ~m_axis_tdata;
         check("stream_word", m_axis_tdata, w);
         got_n++;
      end
      p_t_hold = m_axis_tvalid && !m_axis_tready;
      p_tdata  = m_axis_tdata;

      if (!busy) idle_run++;
      else if (idle_run > 0) begin idle_log.push_back(idle_run); idle_run = 0; end
   endtask

   task automatic tick();
      @(negedge ACLK);
      if (ARESETN) slave_step();
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, bad;
      int unsigned g0, w0, s0;

      vec[0] = '{3, 3, 0, 0};
      vec[1] = '{40, 16, 16, 8};
      vec[2] = '{16, 16, 0, 0};
      vec[3] = '{17, 16, 1, 0};
      vec[4] = '{1, 1, 0, 0};
      vec[5] = '{0, 0, 0, 0};

      enable = 0; flush_req = 0; err_clr = 0;
      rnd_ready = 0; poll_chk_en = 0;
      got_n = 0; n_writes = 0; n_pushed = 0; next_word = 32'd1;
      last_awaddr = '0; last_wdata = '0; last_wstrb = '0;
      slave_reset();
      repeat (3) @(negedge ACLK);

      check("rst_arvalid", {31'd0, m_axi_arvalid}, 0);
      check("rst_rready",  {31'd0, m_axi_rready}, 0);
      check("rst_awvalid", {31'd0, m_axi_awvalid}, 0);
      check("rst_wvalid",  {31'd0, m_axi_wvalid}, 0);
      check("rst_bready",  {31'd0, m_axi_bready}, 0);
      check("rst_tvalid",  {31'd0, m_axis_tvalid}, 0);
      check("rst_tdata",   m_axis_tdata, 0);
      check("rst_araddr",  m_axi_araddr, 0);
      check("rst_awaddr",  m_axi_awaddr, 0);
      check("rst_err",     {31'd0, err}, 0);
      check("rst_busy",    {31'd0, busy}, 0);
      check("const_wstrb", {28'd0, m_axi_wstrb}, 32'hF);
      check("const_prot",  {26'd0, m_axi_arprot, m_axi_awprot}, 0);
      ARESETN = 1;

      // occupancy table
      enable = 1;
      n = 0; while (!m_axi_arvalid && n < 300) begin tick(); n++; end
      check("first_poll", {31'd0, m_axi_arvalid}, 1);
      for (int r = 0; r < 6; r++) begin
         n = 0; while (busy && n < 300) begin tick(); n++; end
         pops_log.delete(); idle_log.delete(); poll_open = 0; g0 = got_n;
         fill(vec[r].n_words);
         n = 0; while (pops_log.size() < 3 && n < 3000) begin tick(); n++; end
         check($sformatf("row%0d_polls", r), pops_log.size(), 3);
         if (pops_log.size() >= 3) begin
            check($sformatf("row%0d_pops0", r), pops_log[0], vec[r].p0);
            check($sformatf("row%0d_pops1", r), pops_log[1], vec[r].p1);
            check($sformatf("row%0d_pops2", r), pops_log[2], vec[r].p2);
         end
         check($sformatf("row%0d_delivered", r), got_n - g0, vec[r].n_words);
         bad = 0;
         foreach (idle_log[i]) if (idle_log[i] != POLL) bad++;
         check($sformatf("row%0d_poll_interval", r), bad, 0);
         check($sformatf("row%0d_idle_seen", r), {31'd0, idle_log.size() > 0}, 1);
      end

      // stream stall with a flush requested mid-drain
      n = 0; while (busy && n < 300) begin tick(); n++; end
      stall_hold = 1; g0 = got_n; w0 = n_writes;
      fill(5);
      n = 0; while (!m_axis_tvalid && n < 300) begin tick(); n++; end
      check("stall_tvalid_up", {31'd0, m_axis_tvalid}, 1);
      s0 = m_axis_tdata;
      flush_req = 1; tick(); flush_req = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("stall_tvalid", {31'd0, m_axis_tvalid}, 1);
         check("stall_tdata", m_axis_tdata, s0);
         check("stall_no_ar", {31'd0, m_axi_arvalid}, 0);
      end
      stall_hold = 0;
      n = 0; while (got_n - g0 < 5 && n < 500) begin tick(); n++; end
      check("flush_drain_all", got_n - g0, 5);
      check("flush_after_drain", n_writes, w0);
      n = 0; while (n_writes == w0 && n < 300) begin tick(); n++; end
      check("flush_write_seen", n_writes, w0 + 1);
      check("flush_awaddr", last_awaddr, CTRL_A);
      check("flush_wdata", last_wdata, 32'd1);
      check("flush_wstrb", {28'd0, last_wstrb}, 32'hF);
      pops_log.delete(); poll_open = 0;
      n = 0; while (pops_log.size() < 1 && n < 500) begin tick(); n++; end
      check("post_flush_pops", (pops_log.size() > 0) ? pops_log[0] : 32'hFFFF, 0);

      // flush serviced from IDLE empties the slave FIFO
      enable = 0;
      n = 0; while (busy && n < 300) begin tick(); n++; end
      repeat (3) tick();
      for (int i = 0; i < 4; i++) fifo_q.push_back(32'hF000 + i);
      g0 = got_n; w0 = n_writes;
      flush_req = 1; tick(); flush_req = 0;
      n = 0; while (n_writes == w0 && n < 200) begin tick(); n++; end
      check("idle_flush_write", n_writes, w0 + 1);
      check("idle_flush_empty", fifo_q.size(), 0);
      check("idle_flush_no_stream", got_n, g0);
      check("idle_flush_err", {31'd0, err}, 0);

      // SLVERR on the first data read drops that word
      enable = 1; slverr_next = 1; g0 = got_n;
      fill(3);
      n = 0; while (!err && n < 500) begin tick(); n++; end
      check("slverr_err_set", {31'd0, err}, 1);
      n = 0; while (exp_q.size() > 0 && n < 1000) begin tick(); n++; end
      repeat (2) tick();
      check("slverr_delivered", got_n - g0, 2);
      check("slverr_sticky", {31'd0, err}, 1);
      err_clr = 1; tick(); err_clr = 0; tick();
      check("err_cleared", {31'd0, err}, 0);

      // read response withheld
      n = 0; while (busy && n < 300) begin tick(); n++; end
      withhold_r = 1; fill(2);
      n = 0; while (!m_axi_rready && n < 300) begin tick(); n++; end
      check("withhold_rready", {31'd0, m_axi_rready}, 1);
`ifdef DRAIN_TIMEOUT_EN
      repeat (TO_CYC - 1) tick();
      check("to_not_yet_rready", {31'd0, m_axi_rready}, 1);
      check("to_not_yet_err", {31'd0, err}, 0);
      tick();
      check("to_err", {31'd0, err}, 1);
      check("to_rready_drop", {31'd0, m_axi_rready}, 0);
      check("to_idle", {31'd0, busy}, 0);
`else
      repeat (1000) tick();
      check("no_to_rready", {31'd0, m_axi_rready}, 1);
      check("no_to_busy", {31'd0, busy}, 1);
      check("no_to_err", {31'd0, err}, 0);
`endif

      // asynchronous reset in the middle of a transaction
      @(negedge ACLK); #2 ARESETN = 0; #1;
      check("arst_rready", {31'd0, m_axi_rready}, 0);
      check("arst_arvalid", {31'd0, m_axi_arvalid}, 0);
      check("arst_tvalid", {31'd0, m_axis_tvalid}, 0);
      check("arst_busy", {31'd0, busy}, 0);
      check("arst_err", {31'd0, err}, 0);
      check("arst_tdata", m_axis_tdata, 0);
      slave_reset();
      @(negedge ACLK); ARESETN = 1;

      // randomized traffic against the push-order scoreboard
      rnd_ready = 1; poll_chk_en = 1; enable = 1; g0 = got_n; s0 = n_pushed;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 4 && fifo_q.size() < 60) fill($urandom_range(1, 3));
         tick();
      end
      n = 0;
      while ((fifo_q.size() > 0 || exp_q.size() > 0) && n < 8000) begin tick(); n++; end
      check("rand_drained", exp_q.size(), 0);
      check("rand_delivered", got_n - g0, n_pushed - s0);
      check("rand_err", {31'd0, err}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_drain_ctrl.md
Name: fifo_drain_ctrl

Overview:
- AXI4-Lite master that sequences the simple_fifo peripheral: polls its occupancy register, pops up to MAX_BURST words through the data register, and forwards each word on an AXI-Stream master port.
- Also issues the FIFO flush command on request.
- Sits between the interconnect master port and the downstream radio sample consumer, replacing software polling.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- C_M_AXI_DATA_WIDTH, 32, AXI data width (32 only)
- BASE_ADDR, 32'h0000_0000, base address of the simple_fifo slave
- DATA_OFFSET, 32'h0, data register offset; each read pops one word
- COUNT_OFFSET, 32'h4, occupancy register offset, count in [15:0]
- CTRL_OFFSET, 32'h8, control register offset; writing 1 flushes the FIFO
- MAX_BURST, 16, max pops per poll (1..255)
- POLL_INTERVAL, 64, idle cycles between polls (>=1)
- TIMEOUT_CYCLES, 256, response timeout, used only with the optional feature

Ports:
- ACLK in 1: clock
- ARESETN in 1: asynchronous, active-low reset
- enable in 1: level; 0 stops new polls after the current word is delivered
- flush_req in 1: single-cycle pulse requesting a FIFO flush
- m_axi_araddr out 32: read address
- m_axi_arprot out 3: constant 3'b000
- m_axi_arvalid out 1: read address valid
- m_axi_arready in 1: read address ready
- m_axi_rdata in 32: read data
- m_axi_rresp in 2: read response
- m_axi_rvalid in 1: read data valid
- m_axi_rready out 1: read data ready
- m_axi_awaddr out 32: write address
- m_axi_awprot out 3: constant 3'b000
- m_axi_awvalid out 1: write address valid
- m_axi_awready in 1: write address ready
- m_axi_wdata out 32: write data
- m_axi_wstrb out 4: constant 4'hF
- m_axi_wvalid out 1: write data valid
- m_axi_wready in 1: write data ready
- m_axi_bresp in 2: write response
- m_axi_bvalid in 1: write response valid
- m_axi_bready out 1: write response ready
- m_axis_tdata out 32: drained word
- m_axis_tvalid out 1: stream valid
- m_axis_tready in 1: stream ready
- busy out 1: high in any state other than IDLE/WAIT
- err out 1: sticky; set on any non-OKAY response
- err_clr in 1: pulse clearing err

Behaviour:
- Reset: all valid/ready outputs 0, addresses 0, tdata 0, err 0, state IDLE, timer 0, remaining 0.
- States: IDLE, WAIT, CNT_AR, CNT_R, DAT_AR, DAT_R, STREAM, FL_AW, FL_B.
- IDLE: go to WAIT when enable=1; timer loads POLL_INTERVAL.
- WAIT: timer decrements each cycle; at 0 go to CNT_AR.
- CNT_AR: arvalid=1, araddr=BASE+COUNT_OFFSET; hold until arready; then CNT_R.
- CNT_R: rready=1; on rvalid, remaining = min(rdata[15:0], MAX_BURST).
  - remaining 0, or rresp!=OKAY: go to WAIT with the timer reloaded.
- DAT_AR: araddr=BASE+DATA_OFFSET, then DAT_R.
- DAT_R: on rvalid, latch rdata into tdata and go to STREAM.
  - rresp!=OKAY: set err, drop the word, go to WAIT.
- STREAM: tvalid=1; tdata is held stable until tready.
  - On tready, decrement remaining.
  - remaining>0 and enable=1: go to DAT_AR.
  - Otherwise: WAIT, or IDLE if enable=0.
- Per transaction:
  - No AR reissue before the R handshake; exactly one outstanding.
  - rready is asserted only in the *_R states.
- Flush:
  - flush_req latched into flush_pend (sticky until serviced).
  - Serviced only from IDLE or WAIT; never mid-drain.
  - FL_AW: awvalid and wvalid both asserted, awaddr=BASE+CTRL_OFFSET, wdata=1. Each valid drops independently on its own ready.
  - When both are accepted, go to FL_B with bready=1.
  - On bvalid: clear flush_pend; err is set if bresp!=OKAY; return to WAIT with the timer reloaded.
- Priority: flush_pend beats poll expiry on the same cycle.
- Errors: err_clr and a new error on the same cycle leave err=1.
- enable dropping mid-drain: finish the current word, then IDLE. Pending flush still executes.
- Asynchronous reset mid-transaction: immediate return to reset values; the slave is responsible for its own reset.

Optional Feature:
- Macro: DRAIN_TIMEOUT_EN.
- Defined:
  - A counter runs in CNT_R, DAT_R and FL_B.
  - Reaching TIMEOUT_CYCLES without the valid: set err, deassert rready/bready, go to IDLE, clear flush_pend.
- Undefined: waits indefinitely; no counter logic is synthesized.

Test Plan:
- Count=3, MAX_BURST=16, tready=1 -> three DATA reads; tdata sequence 0x1,0x2,0x3 from the FIFO; then WAIT; next poll after 64 cycles.
- Count=40 -> exactly 16 pops, then WAIT; remaining words drained on subsequent polls (16,16,8).
- tready held 0 for 20 cycles in STREAM -> tvalid=1, tdata stable, no AR issued; resumes on tready.
- flush_req pulsed during a drain of 5 -> all 5 delivered, then an AW/W write of 0x1 to BASE+0x8; next poll reads count 0.
- Slave returns SLVERR on a data read -> err=1, no tvalid for that word; err_clr -> err=0.
- With DRAIN_TIMEOUT_EN: rvalid withheld -> err=1 after 256 cycles, state IDLE. Without it: still waiting at 1000 cycles.
